counter4_updown: RTL

Synchronous modulo-MOD up/down counter with enable, parallel load, single-step mode and carry/borrow output for cascading. It sits directly downstream of the D-latch/flip-flop storage cells in the 4-bit counter datapath. It produces the next-state value those cells hold and the count presented to the display and cascade logic. Single-step mode lets a bench or board button advance the count one event at a time for debugging.

---
 rtl/counter4_updown_if.sv | 42 ++++
 rtl/counter4_updown.sv | 96 +++++++++
 2 files changed

// File: rtl/counter4_updown_if.sv
// counter4_updown_if
//   Control and status bundle for the modulo up/down counter.
//   master modport: the controller side (drives en/up/load/step/clr_err,
//                   observes count/tc/carry/err).
//   slave modport:  the counter itself.
//   Signals:
//     en        count enable
//     up        direction, 1 = increment, 0 = decrement
//     load      synchronous parallel load request
//     load_val  value to load (WIDTH bits)
//     step_mode 0 = free run, 1 = count only on step edges
//     step      asynchronous pushbutton level
//     clr_err   synchronous clear of err
//     count     registered count (WIDTH bits)
//     tc        terminal count, combinational from count and up
//     carry     one-cycle pulse on wrap
//     err       sticky out-of-range load flag
interface counter4_updown_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             step_mode;
    logic             step;
    logic             clr_err;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             carry;
    logic             err;

    modport master (
        output en, up, load, load_val, step_mode, step, clr_err,
        input  count, tc, carry, err
    );

    modport slave (
        input  en, up, load, load_val, step_mode, step, clr_err,
        output count, tc, carry, err
    );
endinterface

// File: rtl/counter4_updown.sv
// counter4_updown
//   Modulo-MOD up/down counter with enable, parallel load, single-step mode
//   and a registered carry/borrow pulse for cascading.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      counter4_updown_if.slave (controls in, count/tc/carry/err out)
//   Parameters: WIDTH is the counter width in bits; the modulus is legal
//   over 2..2**WIDTH and the count runs from zero to modulus minus one.
module counter4_updown #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input logic              clk,
    input logic              reset_n,
    counter4_updown_if.slave bus
);
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MOD - 1);
    // One extra bit so MOD = 2**WIDTH compares correctly against load_val.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

    logic             s1;
    logic             s2;
    logic             s3;
    logic [WIDTH-1:0] count_q;
    logic             carry_q;
    logic             err_q;
    logic             step_pulse;
    logic             cev;
    logic             load_oor;

    // Step synchronizer plus edge flop. These track step in both modes so
    // entering step mode with step already high yields no event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.step;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        step_pulse = s2 & ~s3;
        cev        = bus.en & (bus.step_mode ? step_pulse : 1'b1);
        load_oor   = ({1'b0, bus.load_val} >= MOD_EXT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            carry_q <= 1'b0;
        end else if (bus.load) begin
            // Out-of-range loads saturate to the last legal state.
            count_q <= load_oor ? LAST : bus.load_val;
            carry_q <= 1'b0;
        end else if (cev && bus.up) begin
            if (count_q == LAST) begin
                count_q <= '0;
                carry_q <= 1'b1;
            end else begin
                count_q <= count_q + WIDTH'(1);
                carry_q <= 1'b0;
            end
        end else if (cev) begin
            if (count_q == '0) begin
                count_q <= LAST;
                carry_q <= 1'b1;
            end else begin
                count_q <= count_q - WIDTH'(1);
                carry_q <= 1'b0;
            end
        end else begin
            carry_q <= 1'b0;
        end
    end

    // Setting err takes precedence over clearing it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (bus.load && load_oor) begin
            err_q <= 1'b1;
        end else if (bus.clr_err) begin
            err_q <= 1'b0;
        end
    end

    assign bus.count = count_q;
    assign bus.carry = carry_q;
    assign bus.err   = err_q;
    assign bus.tc    = bus.up ? (count_q == LAST) : (count_q == '0);
endmodule
